// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for serial_subtractor.
// SUB_OVF_EN adds the overflow_out result signal.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             borrow_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
`ifdef SUB_OVF_EN
  logic             overflow_out;

  modport master (
    output start_in, a_in, b_in, borrow_in,
    input  busy_out, done_out, diff_out, borrow_out, overflow_out
  );
  modport slave (
    input  start_in, a_in, b_in, borrow_in,
    output busy_out, done_out, diff_out, borrow_out, overflow_out
  );
`else
  modport master (
    output start_in, a_in, b_in, borrow_in,
    input  busy_out, done_out, diff_out, borrow_out
  );
  modport slave (
    input  start_in, a_in, b_in, borrow_in,
    output busy_out, done_out, diff_out, borrow_out
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, one bit per clock.
// Optional macro SUB_OVF_EN adds a signed-overflow flag (overflow_out).
//
// state | meaning
// IDLE  | waiting for start_in; results held
// RUN   | shifting one bit per edge through the full-subtractor cell
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_accept;
  logic             w_complete;

`ifdef SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;
`endif

  always_comb begin
    w_state_next = r_state;
    w_d          = r_a[0] ^ r_b[0] ^ r_br;
    w_br_next    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_res_next   = {w_d, r_res[WIDTH-1:1]};
    w_last       = (r_cnt == CW'(WIDTH - 1));
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_in) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_complete   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
`ifdef SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_done  <= w_complete;
      if (w_accept) begin
        r_a     <= bus.a_in;
        r_b     <= bus.b_in;
        r_br    <= bus.borrow_in;
        r_cnt   <= '0;
`ifdef SUB_OVF_EN
        r_a_msb <= bus.a_in[WIDTH-1];
        r_b_msb <= bus.b_in[WIDTH-1];
`endif
      end else if (r_state == RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= w_res_next;
        r_br  <= w_br_next;
        r_cnt <= r_cnt + 1'b1;
      end
      // The last bit computed is the MSB of the result, so w_d is diff_msb here.
      if (w_complete) begin
        r_diff <= w_res_next;
        r_bout <= w_br_next;
`ifdef SUB_OVF_EN
        r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
      end
    end
  end

  assign bus.busy_out   = (r_state == RUN);
  assign bus.done_out   = r_done;
  assign bus.diff_out   = r_diff;
  assign bus.borrow_out = r_bout;
`ifdef SUB_OVF_EN
  assign bus.overflow_out = r_ovf;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial multi-bit subtractor. Computes diff = a - b - borrow_in, one bit per clock, LSB first.
- Built around a full-subtractor cell and a single registered borrow.
- Companion to the combinational full-adder cell: it is the subtract direction, traded for area over latency.
- Sits in datapaths where a WIDTH-bit subtract can tolerate WIDTH cycles of latency behind a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  request pulse; sampled only when busy_out=0.
- a_in  input  WIDTH  minuend; captured on the accepting edge.
- b_in  input  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  input  1  initial borrow; captured on the accepting edge.
- busy_out  output  1  high while an operation is in progress.
- done_out  output  1  one-cycle completion pulse.
- diff_out  output  WIDTH  result; holds its value until the next completion.
- borrow_out  output  1  final borrow (1 means a < b + borrow_in, unsigned).

Behaviour:
- Reset (rst_n_in low, asynchronous): state=IDLE; busy_out, done_out, diff_out, borrow_out, all shift registers, the borrow register and the bit counter are all 0.
- Release of reset is synchronous to clk_in.
- States: IDLE, RUN.
- IDLE:
  - busy_out=0.
  - On an edge with start_in=1: load the a and b shift registers, set borrow register <= borrow_in, set counter <= 0, go to RUN.
- RUN:
  - busy_out=1.
  - Each edge uses the current LSBs a0, b0 and registered borrow br.
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the result register from the MSB side (right shift); the a and b registers shift right; counter increments.
- Completion:
  - On the edge where counter == WIDTH-1: diff_out <= final result (including this bit), borrow_out <= br_next, done_out <= 1, state <= IDLE.
  - done_out is high for exactly one cycle.
- Latency: accepted on edge 0; done_out and results are visible after edge WIDTH. Throughput is one operation per WIDTH+1 cycles at most.
- start_in while busy_out=1 is ignored; operands are not re-captured.
- Back-to-back: start_in=1 during the done_out cycle (state already IDLE) is accepted on that edge.
- diff_out and borrow_out change only on a completion edge or on reset. They are stable at all other times, including through the next operation until it completes.
- Reset mid-operation aborts immediately: no done_out pulse, and outputs return to 0.
- Arithmetic is modulo 2^WIDTH, unsigned. The borrow chain uses no sign interpretation.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined:
  - Adds output port overflow_out (1 bit), reset 0.
  - Updated only on completion edges, together with diff_out.
  - overflow_out = (a_msb ^ b_msb) & (a_msb ^ diff_msb), i.e. signed two's-complement overflow for a - b.
  - a_msb and b_msb are registered at capture.
- Undefined: the port and its capture registers are absent. All other behaviour is identical.

Test Plan (WIDTH=8):
- Basic subtract: a=0x35, b=0x12, borrow_in=0, start pulse -> busy_out high 8 cycles; done_out pulses once after edge 8; diff_out=0x23, borrow_out=0.
- Underflow: a=0x00, b=0x01, borrow_in=0 -> diff_out=0xFF, borrow_out=1.
- Initial borrow: a=0x10, b=0x0F, borrow_in=1 -> diff_out=0x00, borrow_out=0.
- Handshake:
  - Re-assert start_in with a=0xFF, b=0x00 at cycle 3 of a running 0x35-0x12 op -> ignored; result is 0x23.
  - Start asserted during the done_out cycle with a=0x05, b=0x07 -> accepted; next done gives diff_out=0xFE, borrow_out=1; previous diff_out holds 0x23 until then.
- Reset mid-op: drop rst_n_in low asynchronously (between edges) after edge 3 of an op -> busy_out, diff_out, borrow_out immediately 0; no done_out pulse after release; the next op works normally.
- With SUB_OVF_EN:
  - a=0x80, b=0x01 -> diff_out=0x7F, borrow_out=0, overflow_out=1.
  - a=0x7F, b=0x01 -> diff_out=0x7E, overflow_out=0.
